alu_sequencer: RTL and testbench

Issue-side sequencer for the 64-bit single-cycle ALU. It accepts one RV64 R-type or I-type integer instruction at a time over a valid/ready handshake and decodes it into the ALU's 3-bit control code and operands. Multi-bit shifts are performed by iterating the ALU's 1-bit shift operation. The result is held on a valid/ready output port until the writeback stage consumes it.

---
 rtl/alu_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Issue-side sequencer: decodes one RV64 R/I-type ALU op and executes it on an external 1-cycle ALU.
// Latency 1 cycle after accept, or N cycles for a shift by N >= 1; holds DONE until out_ready, accepts nothing while busy.
module alu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [63:0] rs1_val,
  input  logic [63:0] rs2_val,
  output logic [63:0] alu_in_A,
  output logic [63:0] alu_in_B,
  output logic [2:0]  alu_control,
  input  logic [63:0] alu_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;

  localparam logic [2:0] CTL_ADD = 3'b000;
  localparam logic [2:0] CTL_SUB = 3'b001;
  localparam logic [2:0] CTL_AND = 3'b010;
  localparam logic [2:0] CTL_OR  = 3'b011;
  localparam logic [2:0] CTL_SLL = 3'b100;
  localparam logic [2:0] CTL_SRL = 3'b101;
  localparam logic [6:0] OP_REG  = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;

  typedef struct packed {
    logic        illegal;
    logic        is_shift;
    logic [5:0]  shamt;
    logic [2:0]  ctrl;
    logic [63:0] opb;
  } dec_t;

  state_t      r_state;
  logic [63:0] r_alu_a;
  logic [63:0] r_alu_b;
  logic [2:0]  r_alu_ctrl;
  logic [63:0] r_acc;
  logic [5:0]  r_cnt;
  logic        r_is_shift;
  logic        r_illegal_op;
  logic        r_out_valid;
  logic [63:0] r_result;
  logic        r_illegal;

  dec_t        w_dec;
  logic [6:0]  w_opcode;
  logic [6:0]  w_funct7;
  logic [2:0]  w_funct3;
  logic [63:0] w_imm;
  logic        w_unused;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_funct7 = instr[31:25];
  assign w_imm    = {{52{instr[31]}}, instr[31:20]};
  // Register specifiers are resolved upstream; only the values arrive here.
  assign w_unused = ^{instr[19:15], instr[11:7]};

  always_comb begin
    w_dec         = '0;
    w_dec.illegal = 1'b1;
    w_dec.opb     = rs2_val;
    if (w_opcode == OP_REG) begin
      if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
        w_dec.ctrl    = CTL_SUB;
        w_dec.illegal = 1'b0;
      end else if (w_funct7 == 7'b0000000) begin
        case (w_funct3)
          3'b000: begin w_dec.ctrl = CTL_ADD; w_dec.illegal = 1'b0; end
          3'b111: begin w_dec.ctrl = CTL_AND; w_dec.illegal = 1'b0; end
          3'b110: begin w_dec.ctrl = CTL_OR;  w_dec.illegal = 1'b0; end
          3'b001: begin
            w_dec.ctrl     = CTL_SLL;
            w_dec.is_shift = 1'b1;
            w_dec.shamt    = rs2_val[5:0];
            w_dec.illegal  = 1'b0;
          end
          3'b101: begin
            w_dec.ctrl     = CTL_SRL;
            w_dec.is_shift = 1'b1;
            w_dec.shamt    = rs2_val[5:0];
            w_dec.illegal  = 1'b0;
          end
          default: ;
        endcase
      end
    end else if (w_opcode == OP_IMM) begin
      w_dec.opb = w_imm;
      case (w_funct3)
        3'b000: begin w_dec.ctrl = CTL_ADD; w_dec.illegal = 1'b0; end
        3'b111: begin w_dec.ctrl = CTL_AND; w_dec.illegal = 1'b0; end
        3'b110: begin w_dec.ctrl = CTL_OR;  w_dec.illegal = 1'b0; end
        3'b001: begin
          if (instr[31:26] == 6'b000000) begin
            w_dec.ctrl     = CTL_SLL;
            w_dec.is_shift = 1'b1;
            w_dec.shamt    = instr[25:20];
            w_dec.illegal  = 1'b0;
          end
        end
        3'b101: begin
          if (instr[31:26] == 6'b000000) begin
            w_dec.ctrl     = CTL_SRL;
            w_dec.is_shift = 1'b1;
            w_dec.shamt    = instr[25:20];
            w_dec.illegal  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_ctrl   <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_is_shift   <= 1'b0;
      r_illegal_op <= 1'b0;
      r_out_valid  <= 1'b0;
      r_result     <= '0;
      r_illegal    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_acc        <= rs1_val;
            r_is_shift   <= w_dec.is_shift;
            r_illegal_op <= w_dec.illegal;
            r_alu_a      <= rs1_val;
            r_alu_ctrl   <= w_dec.ctrl;
            if (w_dec.is_shift && w_dec.shamt != 6'd0) begin
              r_cnt   <= w_dec.shamt;
              r_alu_b <= '0;
              r_state <= SHIFT;
            end else begin
              r_cnt   <= '0;
              r_alu_b <= w_dec.opb;
              r_state <= EXEC;
            end
          end
        end
        EXEC: begin
          // A zero-length shift passes rs1 through untouched.
          if (r_illegal_op)    r_result <= '0;
          else if (r_is_shift) r_result <= r_acc;
          else                 r_result <= alu_out;
          r_illegal   <= r_illegal_op;
          r_out_valid <= 1'b1;
          r_alu_a     <= '0;
          r_alu_b     <= '0;
          r_alu_ctrl  <= '0;
          r_state     <= DONE;
        end
        SHIFT: begin
          r_acc <= alu_out;
          r_cnt <= r_cnt - 6'd1;
          if (r_cnt == 6'd1) begin
            r_result    <= alu_out;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b1;
            r_alu_a     <= '0;
            r_alu_ctrl  <= '0;
            r_state     <= DONE;
          end else begin
            r_alu_a <= alu_out;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE) && !reset;
  assign alu_in_A    = r_alu_a;
  assign alu_in_B    = r_alu_b;
  assign alu_control = r_alu_ctrl;
  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign illegal     = r_illegal;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU plus an instruction-level reference model, directed and random traffic.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [63:0] rs1_val;
  logic [63:0] rs2_val;
  logic [63:0] alu_in_A;
  logic [63:0] alu_in_B;
  logic [2:0]  alu_control;
  logic [63:0] alu_out;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .rs1_val     (rs1_val),
    .rs2_val     (rs2_val),
    .alu_in_A    (alu_in_A),
    .alu_in_B    (alu_in_B),
    .alu_control (alu_control),
    .alu_out     (alu_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .illegal     (illegal)
  );

  // Single-cycle ALU the sequencer drives.
  always_comb begin
    alu_out = '0;
    case (alu_control)
      3'b000: alu_out = alu_in_A + alu_in_B;
      3'b001: alu_out = alu_in_A - alu_in_B;
      3'b010: alu_out = alu_in_A & alu_in_B;
      3'b011: alu_out = alu_in_A | alu_in_B;
      3'b100: alu_out = alu_in_A << 1;
      3'b101: alu_out = alu_in_A >> 1;
      default: alu_out = '0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic [31:0] mk_i(input logic [11:0] imm, input logic [2:0] f3);
    return {imm, 5'd1, f3, 5'd3, 7'b0010011};
  endfunction

  // Architectural meaning of an instruction: result, illegal flag, shift distance.
  function automatic void ref_model(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] res, output logic ill, output int nsh);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    op  = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    imm = {{52{ins[31]}}, ins[31:20]};
    res = '0;
    ill = 1'b1;
    nsh = 0;
    if (op == 7'h33) begin
      if (f7 == 7'h20 && f3 == 3'd0) begin res = a - b; ill = 1'b0; end
      else if (f7 == 7'h00) begin
        case (f3)
          3'd0: begin res = a + b; ill = 1'b0; end
          3'd7: begin res = a & b; ill = 1'b0; end
          3'd6: begin res = a | b; ill = 1'b0; end
          3'd1: begin res = a << b[5:0]; nsh = int'(b[5:0]); ill = 1'b0; end
          3'd5: begin res = a >> b[5:0]; nsh = int'(b[5:0]); ill = 1'b0; end
          default: ;
        endcase
      end
    end else if (op == 7'h13) begin
      case (f3)
        3'd0: begin res = a + imm; ill = 1'b0; end
        3'd7: begin res = a & imm; ill = 1'b0; end
        3'd6: begin res = a | imm; ill = 1'b0; end
        3'd1: if (ins[31:26] == 6'd0) begin res = a << ins[25:20]; nsh = int'(ins[25:20]); ill = 1'b0; end
        3'd5: if (ins[31:26] == 6'd0) begin res = a >> ins[25:20]; nsh = int'(ins[25:20]); ill = 1'b0; end
        default: ;
      endcase
    end
  endfunction

  task automatic wait_ready();
    int cyc = 0;
    while (!in_ready && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("in_ready_before_issue", 64'(in_ready), 64'd1);
  endtask

  task automatic issue(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                       input int hold, input bit early);
    logic [63:0] exp_res;
    logic        exp_ill;
    int          nsh;
    int          exp_lat;
    int          cyc;
    int          nctl;
    ref_model(ins, a, b, exp_res, exp_ill, nsh);
    exp_lat = (nsh > 0) ? nsh : 1;
    wait_ready();
    in_valid = 1'b1;
    instr    = ins;
    rs1_val  = a;
    rs2_val  = b;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    instr     = $urandom;
    rs1_val   = {$urandom, $urandom};
    rs2_val   = {$urandom, $urandom};
    out_ready = early;
    check("busy_in_ready", 64'(in_ready), 64'd0);
    cyc  = 0;
    nctl = 0;
    while (!out_valid && cyc < 200) begin
      if (alu_control == 3'b100 || alu_control == 3'b101) nctl++;
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 64'(cyc), 64'(exp_lat));
    if (nsh > 0) check("shift_cycles", 64'(nctl), 64'(nsh));
    check("result", result, exp_res);
    check("illegal", 64'(illegal), 64'(exp_ill));
    check("done_alu_ctrl", 64'(alu_control), 64'd0);
    check("done_alu_a", alu_in_A, 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_result", result, exp_res);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_drop", 64'(out_valid), 64'd0);
    check("ready_return", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] ins;
    logic [11:0] imm;
    bit          early;
    int          hold;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    instr     = '0;
    rs1_val   = '0;
    rs2_val   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    check("rst_alu_a", alu_in_A, 64'd0);
    check("rst_alu_b", alu_in_B, 64'd0);
    check("rst_alu_ctrl", 64'(alu_control), 64'd0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    issue(32'h0000_0033, 64'd5, 64'd7, 0, 1'b0);
    issue(mk_r(7'h20, 3'd0), 64'd0, 64'd1, 0, 1'b0);
    issue(mk_i(12'hFFF, 3'd0), 64'd1, {$urandom, $urandom}, 0, 1'b0);
    issue(mk_i(12'd63, 3'd1), 64'd1, 64'd0, 0, 1'b0);
    issue(mk_r(7'h00, 3'd5), 64'hAB, 64'h40, 0, 1'b0);
    issue(32'h0200_0033, {$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b0);
    issue(32'h0000_0033, 64'd3, 64'd4, 0, 1'b0);
    issue(mk_i(12'h00F, 3'd6), 64'hF0, 64'd0, 10, 1'b0);
    issue(mk_r(7'h00, 3'd7), 64'hFF00FF00, 64'h0FF00FF0, 0, 1'b1);

    // Abort a 20-bit shift in its fifth SHIFT cycle.
    wait_ready();
    in_valid = 1'b1;
    instr    = mk_i(12'd20, 3'd1);
    rs1_val  = 64'h0000_0000_0000_0F0F;
    rs2_val  = '0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("shift_ctrl_c1", 64'(alu_control), 64'd4);
    repeat (4) begin @(posedge clk); #1; end
    check("shift_a_c5", alu_in_A, 64'h0000_0000_0000_F0F0);
    reset = 1'b1;
    #1;
    check("rst_mid_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_result", result, 64'd0);
    check("abort_alu_a", alu_in_A, 64'd0);
    check("abort_alu_ctrl", 64'(alu_control), 64'd0);
    reset = 1'b0;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    issue(32'h0000_0033, 64'd100, 64'd23, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      imm = 12'($urandom);
      case ($urandom_range(0, 13))
        0:  ins = mk_r(7'h00, 3'd0);
        1:  ins = mk_r(7'h20, 3'd0);
        2:  ins = mk_r(7'h00, 3'd7);
        3:  ins = mk_r(7'h00, 3'd6);
        4:  ins = mk_r(7'h00, 3'd1);
        5:  ins = mk_r(7'h00, 3'd5);
        6:  ins = mk_i(imm, 3'd0);
        7:  ins = mk_i(imm, 3'd7);
        8:  ins = mk_i(imm, 3'd6);
        9:  ins = mk_i({6'b000000, imm[5:0]}, 3'd1);
        10: ins = mk_i({6'b000000, imm[5:0]}, 3'd5);
        11: ins = $urandom;
        12: ins = mk_i({6'b010000, imm[5:0]}, 3'd5);
        default: ins = mk_r(7'h00, 3'd4);
      endcase
      early = ($urandom_range(0, 3) == 0);
      hold  = early ? 0 : int'($urandom_range(0, 3));
      issue(ins, {$urandom, $urandom}, {$urandom, $urandom}, hold, early);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
